branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetched branch predictions; on resolve it emits a registered table update and flushes on mispredict.
// Optional BRANCH_RESOLVE_STATS_EN adds an 8-bit saturating mispredict counter output.
module branch_resolve_queue #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     en,
  input  logic                     fetch_valid,
  input  logic                     fetch_is_branch,
  input  logic [LOWER-1:0]         fetch_addr,
  input  logic                     prediction,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     resolve_jump,
  output logic                     upd_en,
  output logic [LOWER-1:0]         upd_addr,
  output logic                     upd_taken,
  output logic                     upd_jumped,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [7:0]               mispredict_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LOWER-1:0] addr_mem_q [DEPTH];
  logic             pred_mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             upd_en_q, upd_en_d;
  logic [LOWER-1:0] upd_addr_q, upd_addr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             upd_jumped_q, upd_jumped_d;
  logic             mispredict_q, mispredict_d;

  logic push, pop, actual, mis, push_ok;

  always_comb begin
    push    = en & fetch_valid & fetch_is_branch & (~full_q | pop);
    pop     = en & resolve_valid & ~empty_q;
    actual  = resolve_taken | resolve_jump;
    mis     = pop & (pred_mem_q[rd_ptr_q] != actual);
    // A flush discards the same-cycle push along with everything queued
    push_ok = push & ~mis;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    upd_en_d     = pop;
    upd_addr_d   = '0;
    upd_taken_d  = 1'b0;
    upd_jumped_d = 1'b0;
    mispredict_d = mis;
    if (pop) begin
      upd_addr_d   = addr_mem_q[rd_ptr_q];
      upd_taken_d  = resolve_taken;
      upd_jumped_d = resolve_jump;
    end
    if (mis) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      upd_en_q     <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      upd_jumped_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      upd_en_q     <= upd_en_d;
      upd_addr_q   <= upd_addr_d;
      upd_taken_q  <= upd_taken_d;
      upd_jumped_q <= upd_jumped_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry storage is plain data and is left unreset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= fetch_addr;
      pred_mem_q[wr_ptr_q] <= prediction;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [7:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (mis && mis_cnt_q != 8'hFF) mis_cnt_d = mis_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) mis_cnt_q <= '0;
    else         mis_cnt_q <= mis_cnt_d;
  end

  assign mispredict_cnt = mis_cnt_q;
`endif

  assign upd_en     = upd_en_q;
  assign upd_addr   = upd_addr_q;
  assign upd_taken  = upd_taken_q;
  assign upd_jumped = upd_jumped_q;
  assign mispredict = mispredict_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed-vector bench for branch_resolve_queue (DEPTH 4, LOWER 5), with hand sequences for reset and stats.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       en, fetch_valid, fetch_is_branch, prediction;
  logic [4:0] fetch_addr;
  logic       resolve_valid, resolve_taken, resolve_jump;
  logic       upd_en, upd_taken, upd_jumped, mispredict, full, empty;
  logic [4:0] upd_addr;
  logic [2:0] count;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [7:0] mispredict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.LOWER(5), .DEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch),
    .fetch_addr(fetch_addr), .prediction(prediction),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_jump(resolve_jump),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_jumped(upd_jumped),
    .mispredict(mispredict), .full(full), .empty(empty), .count(count)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .mispredict_cnt(mispredict_cnt)
`endif
  );

  typedef struct {
    logic       en, fv, fb;
    logic [4:0] addr;
    logic       pred, rv, rt, rj;
    logic       e_upd;
    logic [4:0] e_addr;
    logic       e_tk, e_jp, e_mis, e_full, e_empty;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en_i, fv, fb, input logic [4:0] a, input logic p, rv, rt, rj,
                              input logic eu, input logic [4:0] ea, input logic et, ej, em, ef, ee,
                              input logic [2:0] ec);
    vec_t v;
    v.en = en_i; v.fv = fv; v.fb = fb; v.addr = a; v.pred = p; v.rv = rv; v.rt = rt; v.rj = rj;
    v.e_upd = eu; v.e_addr = ea; v.e_tk = et; v.e_jp = ej; v.e_mis = em;
    v.e_full = ef; v.e_empty = ee; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b1; fetch_valid = 1'b0; fetch_is_branch = 1'b0; fetch_addr = '0; prediction = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_jump = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic eu, input logic [4:0] ea,
                               input logic et, ej, em, ef, ee, input logic [2:0] ec);
    check({tag, ".upd_en"}, upd_en, eu);
    check({tag, ".upd_addr"}, upd_addr, ea);
    check({tag, ".upd_taken"}, upd_taken, et);
    check({tag, ".upd_jumped"}, upd_jumped, ej);
    check({tag, ".mispredict"}, mispredict, em);
    check({tag, ".full"}, full, ef);
    check({tag, ".empty"}, empty, ee);
    check({tag, ".count"}, count, ec);
  endtask

  task automatic push_one(input logic [4:0] a, input logic p);
    idle_inputs();
    fetch_valid = 1'b1; fetch_is_branch = 1'b1; fetch_addr = a; prediction = p;
    step();
  endtask

  task automatic resolve_one(input logic t, input logic j);
    idle_inputs();
    resolve_valid = 1'b1; resolve_taken = t; resolve_jump = j;
    step();
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    #12;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 1, 0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    //  en fv fb addr p  rv rt rj | upd addr tk jp mis full empty cnt
    add(1, 1, 1,  3, 1,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 1);
    add(1, 1, 1,  7, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 2);
    add(1, 1, 1,  9, 1,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 3);
    add(1, 0, 0,  0, 0,  1, 1, 0,   1,  3, 1, 0, 0,  0, 0, 2);
    add(1, 0, 0,  0, 0,  1, 0, 0,   1,  7, 0, 0, 0,  0, 0, 1);
    add(1, 0, 0,  0, 0,  1, 0, 1,   1,  9, 0, 1, 0,  0, 1, 0);
    add(1, 0, 0,  0, 0,  1, 1, 0,   0,  0, 0, 0, 0,  0, 1, 0);
    add(0, 1, 1, 11, 1,  0, 0, 0,   0,  0, 0, 0, 0,  0, 1, 0);
    add(1, 1, 0, 20, 1,  0, 0, 0,   0,  0, 0, 0, 0,  0, 1, 0);
    add(1, 1, 1,  1, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 1);
    add(1, 1, 1,  2, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 2);
    add(1, 1, 1,  4, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 3);
    add(1, 1, 1,  5, 0,  0, 0, 0,   0,  0, 0, 0, 0,  1, 0, 4);
    add(1, 1, 1,  6, 1,  0, 0, 0,   0,  0, 0, 0, 0,  1, 0, 4);
    add(1, 1, 1,  6, 0,  1, 0, 0,   1,  1, 0, 0, 0,  1, 0, 4);
    add(1, 0, 0,  0, 0,  1, 0, 0,   1,  2, 0, 0, 0,  0, 0, 3);
    add(1, 0, 0,  0, 0,  1, 0, 0,   1,  4, 0, 0, 0,  0, 0, 2);
    add(1, 1, 1, 10, 1,  1, 1, 0,   1,  5, 1, 0, 1,  0, 1, 0);
    add(1, 0, 0,  0, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 1, 0);
    add(1, 1, 1, 12, 1,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 1);
    add(1, 0, 0,  0, 0,  1, 1, 0,   1, 12, 1, 0, 0,  0, 1, 0);
    add(1, 1, 1, 13, 0,  0, 0, 0,   0,  0, 0, 0, 0,  0, 0, 1);
    add(0, 0, 0,  0, 0,  1, 1, 0,   0,  0, 0, 0, 0,  0, 0, 1);
    add(1, 0, 0,  0, 0,  1, 1, 0,   1, 13, 1, 0, 1,  0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; fetch_valid = vecs[i].fv; fetch_is_branch = vecs[i].fb;
      fetch_addr = vecs[i].addr; prediction = vecs[i].pred;
      resolve_valid = vecs[i].rv; resolve_taken = vecs[i].rt; resolve_jump = vecs[i].rj;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].e_upd, vecs[i].e_addr, vecs[i].e_tk,
                    vecs[i].e_jp, vecs[i].e_mis, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_cnt);
    end

    // Mid-stream reset: 3 entries left and an update on the outputs
    push_one(14, 1); push_one(15, 1); push_one(16, 1); push_one(17, 1);
    resolve_one(1, 0);
    check_outputs("pre_rst", 1, 14, 1, 0, 0, 0, 0, 3);
    idle_inputs();
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #3;
    arst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    check_outputs("rst_held", 0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    arst_n = 1'b1;
    resolve_one(1, 0);
    check_outputs("post_rst1", 0, 0, 0, 0, 0, 0, 1, 0);
    resolve_one(0, 1);
    check_outputs("post_rst2", 0, 0, 0, 0, 0, 0, 1, 0);

`ifdef BRANCH_RESOLVE_STATS_EN
    check("stats_reset", mispredict_cnt, 0);
    for (int k = 0; k < 300; k++) begin
      push_one(5'(k), 1'b0);
      resolve_one(1'b1, 1'b0);
      if (k == 253) check("stats_254", mispredict_cnt, 254);
    end
    check("stats_sat", mispredict_cnt, 255);
    check("stats_last_mis", mispredict, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
